// File: rtl/trig_pulse_pkg.sv
// Shared encodings for the multi-channel trigger pulse generator.
package trig_pulse_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_sel_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic edge_hit(input edge_sel_e sel, input logic rise, input logic fall);
    logic hit;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/trig_pulse_gen_if.sv
// Control/status bundle between a trigger source and the pulse generator.
interface trig_pulse_gen_if
  import trig_pulse_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned WW  = 8
) ();

  logic [NCH-1:0] trig;
  logic [WW-1:0]  width;
  edge_sel_e      edge_sel;
  logic           retrig;
  logic           ovr_clr;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] ovr;

  modport master (
    output trig, width, edge_sel, retrig, ovr_clr,
    input  pulse, ovr
  );

  modport slave (
    input  trig, width, edge_sel, retrig, ovr_clr,
    output pulse, ovr
  );

endinterface

// File: rtl/trig_pulse_chan.sv
// One channel: trigger synchroniser, edge detect, length counter FSM and sticky overrun.
module trig_pulse_chan
  import trig_pulse_pkg::*;
#(
  parameter int unsigned WW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig,
  input  logic [WW-1:0] width,
  input  edge_sel_e     edge_sel,
  input  logic          retrig,
  input  logic          ovr_clr,
  output logic          pulse,
  output logic          ovr
);

  logic          s;
  logic          h_q;
  logic          ev;
  logic [WW-1:0] load;
  logic [WW-1:0] cnt_q;
  logic          pulse_q;
  logic          ovr_q;
  state_e        state_q;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign s = trig;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
      end
    end
    assign s = sync_q[SYNC_STAGES-1];
  end

  assign ev = edge_hit(edge_sel, s & ~h_q, ~s & h_q);

  // cnt holds remaining high cycles minus one; width 0 behaves as 1
  assign load = (width == '0) ? '0 : width - WW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
      h_q     <= 1'b0;
    end else begin
      h_q <= s;
      if (ovr_clr) ovr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ev) begin
            pulse_q <= 1'b1;
            cnt_q   <= load;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (ev && (cnt_q == '0 || retrig)) begin
            cnt_q <= load;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WW'(1);
            // set is written after clear so it wins when both occur together
            if (ev) ovr_q <= 1'b1;
          end else begin
            pulse_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pulse = pulse_q;
  assign ovr   = ovr_q;

endmodule

// File: rtl/trig_pulse_gen.sv
// N-channel edge-triggered pulse generator; shared controls fan out to identical channels.
module trig_pulse_gen #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned WW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  trig_pulse_gen_if.slave bus
);

  logic [NCH-1:0] pulse_w;
  logic [NCH-1:0] ovr_w;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    trig_pulse_chan #(
      .WW          (WW),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .trig     (bus.trig[i]),
      .width    (bus.width),
      .edge_sel (bus.edge_sel),
      .retrig   (bus.retrig),
      .ovr_clr  (bus.ovr_clr),
      .pulse    (pulse_w[i]),
      .ovr      (ovr_w[i])
    );
  end

  assign bus.pulse = pulse_w;
  assign bus.ovr   = ovr_w;

endmodule

// File: doc/trig_pulse_gen.md
Name: trig_pulse_gen

Overview:
- Multi-channel edge-triggered pulse generator for the DDS control path. Generates timing strobes for phase reset, frequency-word load and sweep step.
- Each channel synchronises an asynchronous trigger, detects a selectable edge and emits a clean, fully synchronous pulse of programmable length in `clk` cycles.
- Generalises the single-cycle, rising-edge-only pulse generator:
  - N channels
  - width counter
  - edge select
  - retrigger policy
  - overrun flag
  - a single clock domain with no negedge logic

Parameters:
- NCH, 4, number of independent channels
- WW, 8, width of the pulse-length field (max pulse 2^WW-1 cycles)
- SYNC_STAGES, 2, synchroniser flops per trigger input; 0 = bypass for inputs already synchronous to `clk`; legal values 0, 2, 3

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- trig  in  NCH  trigger inputs, asynchronous unless SYNC_STAGES=0
- width  in  WW  pulse length in cycles, shared by all channels; sampled on trigger acceptance
- edge_sel  in  2  edge mode, shared: 00 rising, 01 falling, 10 both, 11 disabled
- retrig  in  1  1 = accepted edge during an active pulse restarts the length count; 0 = such an edge is ignored
- ovr_clr  in  1  synchronous clear of all overrun flags
- pulse  out  NCH  per-channel output pulse, registered
- ovr  out  NCH  per-channel sticky overrun flag, registered

Behaviour:
- Reset (rst_n=0, asynchronous): pulse=0, ovr=0, every synchroniser flop=0, edge-history flop=0, counters=0, all channels IDLE.
  - After release, a trig held high is seen as a rising edge once.
- Synchroniser: trig[i] passes through SYNC_STAGES flops to give s[i]. h[i] is registered s[i].
  - Edge detection is combinational on (s, h):
    - rise = s & ~h
    - fall = ~s & h
  - "ev" is the edge selected by edge_sel. Mode 11 gives ev=0.
- Latency: trig changes before rising edge E0; pulse is high in the cycle after edge E(SYNC_STAGES).
  - SYNC_STAGES=2 gives pulse high after the 3rd edge.
  - SYNC_STAGES=0 gives pulse high after E0.
- Per-channel FSM, states IDLE and ACTIVE; cnt is WW bits.
  - IDLE, ev=1: pulse<=1, cnt<=max(width,1)-1, go ACTIVE.
  - ACTIVE, cnt!=0, ev=0: cnt<=cnt-1.
  - ACTIVE, cnt==0, ev=0: pulse<=0, go IDLE.
  - ACTIVE, cnt==0, ev=1: reload cnt<=max(width,1)-1, stay ACTIVE (back-to-back). This holds in both retrig modes and does not set ovr.
  - ACTIVE, cnt!=0, ev=1, retrig=1: reload cnt from the current width. The pulse is extended and does not drop.
  - ACTIVE, cnt!=0, ev=1, retrig=0: edge discarded, count continues, ovr[i]<=1.
- width=0 is treated as 1. Pulse length is exactly max(width,1) cycles, measured as pulse-high cycles.
- A width change while ACTIVE does not affect the running count, only the next reload.
- ovr: set by the discard condition above, cleared by ovr_clr=1.
  - Set and clear in the same cycle: set wins (flag stays 1).
- edge_sel change: takes effect on the next cycle. A pulse in progress always completes, including under mode 11.
- Channels are fully independent. Simultaneous events on several channels are all served in the same cycle.
- Reset mid-pulse: pulse drops immediately (asynchronous) and no residual pulse appears after release.
- Minimum detectable trigger pulse: for SYNC_STAGES>0, trig must be stable at least 1 clk period plus setup. Shorter glitches may be missed. No requirement on them beyond never producing a pulse shorter than programmed.

Decomposition:
- Package trig_pulse_pkg:
  - edge_sel encodings EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11
  - FSM state encoding ST_IDLE, ST_ACTIVE
- Sub-module trig_pulse_chan: one channel (synchroniser, edge detect, FSM, counter, ovr).
  - The top instantiates NCH copies via generate and fans out the shared controls.

Test Plan:
- Reset/latency: NCH=4, SYNC_STAGES=2, width=5, edge_sel=00; after reset raise trig[0] before edge 10 -> pulse[0] high for exactly 5 cycles starting after edge 12; other pulses and all ovr stay 0.
- Width corners: width=0, then width=1, then width=255 -> pulse lengths 1, 1, 255 cycles; a trig held high never re-fires.
- Retrigger: width=10, retrig=1, second rising edge detected 4 cycles into the pulse -> pulse continuous for 14 cycles, ovr=0. Same with retrig=0 -> 10 cycles, ovr[0]=1 until ovr_clr; set and clear in the same cycle leaves ovr=1.
- Edge modes and back-to-back: edge_sel=10, width=3, trig toggles every 3 synchronous cycles (SYNC_STAGES=0) -> pulse stays high continuously, no ovr. edge_sel=01 -> pulse only on falling edges. edge_sel=11 mid-pulse -> current pulse completes, no new pulses.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 2 of a width-8 pulse -> pulse and ovr go 0 without a clock edge. Release with trig high -> exactly one new pulse.
- Multi-channel concurrency: all 4 triggers rise on the same cycle with width=6 -> 4 identical, aligned 6-cycle pulses. Random independent triggers checked against a cycle-accurate reference model for 10k cycles.
